// File: rtl/nibble_bus_mem_pkg.sv
// Shared definitions for the nibble CPU pin bus and its program/data memory.
// Bus widths are common with the 4-bit accumulator CPU.
package nibble_bus_mem_pkg;

    localparam int BUS_ADDR_W = 6;
    localparam int BUS_DATA_W = 4;

    typedef logic       store_state_t;
    typedef logic [1:0] load_state_t;

    localparam store_state_t S_IDLE = 1'b0;
    localparam store_state_t S_ADDR = 1'b1;

    localparam load_state_t L_IDLE = 2'd0;
    localparam load_state_t L_LOAD = 2'd1;
    localparam load_state_t L_HOLD = 2'd2;

endpackage

// File: rtl/nibble_bus_mem_if.sv
// CPU pin bus plus host load handshake seen by nibble_bus_mem.
// The master side is the CPU/host; the slave side is the memory.
interface nibble_bus_mem_if
    import nibble_bus_mem_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
) ();

    logic [ADDR_W-1:0] bus_addr;
    logic              bus_wcyc;
    logic [DATA_W-1:0] cpu_data;
    logic              cpu_rst;

    logic              load_start;
    logic              host_valid;
    logic [DATA_W-1:0] host_data;
    logic              host_last;
    logic              host_ready;
    logic              load_busy;
    logic              load_done;
    logic              wr_err;

    modport master (
        output bus_addr, bus_wcyc, load_start, host_valid, host_data, host_last,
        input  cpu_data, cpu_rst, host_ready, load_busy, load_done, wr_err
    );

    modport slave (
        input  bus_addr, bus_wcyc, load_start, host_valid, host_data, host_last,
        output cpu_data, cpu_rst, host_ready, load_busy, load_done, wr_err
    );

endinterface

// File: rtl/nibble_bus_mem_array.sv
// Flop-based word array: one synchronous write port, one asynchronous read port.
// The whole array clears on reset so the CPU always boots from a known image.
module nibble_bus_mem_array #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_p,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: resetting every word forces flops rather than RAM macros; the CPU relies on an all-zero image after reset.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/nibble_bus_mem.sv
// Program/data memory on the nibble CPU pin bus: decodes the two-phase store
// protocol and runs a host load that holds the CPU in reset while filling memory.
module nibble_bus_mem
    import nibble_bus_mem_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
) (
    input  logic              clk,
    input  logic              rst_p,
    nibble_bus_mem_if.slave   bus
);

    store_state_t      s_state;
    load_state_t       l_state;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] load_ptr;
    logic              cpu_rst_q;
    logic              wr_err_q;

    logic              load_req;
    logic              load_busy;
    logic              store_en;
    logic              store_wr;
    logic              load_xfer;
    logic              load_end;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign load_busy = (l_state == L_LOAD) || (l_state == L_HOLD);
    assign load_req  = (l_state == L_IDLE) && bus.load_start;
    // A load request in the same cycle as a store phase takes precedence.
    assign store_en  = !load_busy && !cpu_rst_q && !load_req;
    assign store_wr  = store_en && (s_state == S_ADDR) && bus.bus_wcyc;
    assign load_xfer = (l_state == L_LOAD) && bus.host_valid;
    assign load_end  = load_xfer && (bus.host_last || (load_ptr == '1));

    // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            s_state  <= S_IDLE;
            wr_addr  <= '0;
            wr_err_q <= 1'b0;
        end else if (load_req) begin
            s_state  <= S_IDLE;
            wr_err_q <= 1'b0;
        end else if (!store_en) begin
            s_state  <= S_IDLE;
        end else begin
            case (s_state)
                S_IDLE: begin
                    if (bus.bus_wcyc) begin
                        wr_addr <= bus.bus_addr;
                        s_state <= S_ADDR;
                    end
                end
                default: begin
                    if (!bus.bus_wcyc) begin
                        wr_err_q <= 1'b1;
                    end
                    s_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            l_state   <= L_IDLE;
            load_ptr  <= '0;
            cpu_rst_q <= 1'b1;
        end else begin
            case (l_state)
                L_IDLE: begin
                    cpu_rst_q <= bus.load_start;
                    if (bus.load_start) begin
                        l_state  <= L_LOAD;
                        load_ptr <= '0;
                    end
                end
                L_LOAD: begin
                    if (load_end) begin
                        l_state <= L_HOLD;
                    end
                    // The pointer saturates at the top address instead of wrapping.
                    if (load_xfer && (load_ptr != '1)) begin
                        load_ptr <= load_ptr + 1'b1;
                    end
                end
                L_HOLD:  l_state <= L_IDLE;
                default: l_state <= L_IDLE;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        mem_we    = load_xfer || store_wr;
        mem_waddr = wr_addr;
        mem_wdata = bus.bus_addr[DATA_W-1:0];
        if (load_xfer) begin
            mem_waddr = load_ptr;
            mem_wdata = bus.host_data;
        end
    end

    nibble_bus_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .rst_p (rst_p),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (bus.bus_addr),
        .rdata (bus.cpu_data)
    );

    assign bus.cpu_rst    = cpu_rst_q;
    assign bus.host_ready = (l_state == L_LOAD);
    assign bus.load_busy  = load_busy;
    assign bus.load_done  = (l_state == L_HOLD);
    assign bus.wr_err     = wr_err_q;

endmodule

// File: doc/nibble_bus_mem.md
# nibble_bus_mem

64x4 program/data memory that sits directly on the 4-bit accumulator CPU's pin bus and serves its fetch, load and store cycles. It decodes the CPU's two-cycle store protocol (address phase, then data phase, both with write-cycle high) and returns read data combinationally from the presented address. A host load port with valid/ready handshake fills the memory while the block holds the CPU in reset.

## Interface
Parameters:
- ADDR_W, 6, address width; depth = 2**ADDR_W
- DATA_W, 4, word width

Ports:
- clk  in  1  clock; same clock as the CPU
- rst_p  in  1  reset, asynchronous, active-high
- bus_addr  in  ADDR_W  CPU address/data pins (CPU out[5:0])
- bus_wcyc  in  1  CPU write-cycle pin (CPU out[7])
- cpu_data  out  DATA_W  read data to CPU data-in pins
- cpu_rst  out  1  reset to CPU, registered
- load_start  in  1  one-cycle request to begin a host load
- host_valid  in  1  host nibble valid
- host_data  in  DATA_W  host nibble
- host_last  in  1  marks final nibble of load
- host_ready  out  1  block accepts host nibble this cycle
- load_busy  out  1  load in progress
- load_done  out  1  one-cycle pulse at load completion
- wr_err  out  1  sticky store-protocol error

## Operation
- Storage: 64 words, all cleared to 0 by rst_p.
- Read: cpu_data = mem[bus_addr], combinational, always (including during data phase and cpu_rst).
- Store FSM (S_IDLE, S_ADDR):
  - S_IDLE, bus_wcyc=1 at posedge: wr_addr <= bus_addr; -> S_ADDR.
  - S_ADDR, bus_wcyc=1: mem[wr_addr] <= bus_addr[DATA_W-1:0]; -> S_IDLE.
  - S_ADDR, bus_wcyc=0: no write, wr_err <= 1; -> S_IDLE.
  - Store cycles are ignored (FSM held in S_IDLE) while load_busy or cpu_rst.
- Load FSM (L_IDLE, L_LOAD, L_HOLD):
  - L_IDLE: load_start=1 -> L_LOAD, load_ptr <= 0, wr_err <= 0, store FSM -> S_IDLE.
  - L_LOAD: host_ready=1; on host_valid: mem[load_ptr] <= host_data, load_ptr++. If host_last or load_ptr==63 -> L_HOLD (nibble at 63 ends the load; no wrap).
  - L_HOLD: one cycle, -> L_IDLE, load_done=1.
  - load_start outside L_IDLE ignored.
- load_busy = state in {L_LOAD, L_HOLD}.
- cpu_rst: set by rst_p; set on the edge entering L_LOAD; cleared on the first posedge in L_IDLE with no load_start pending (i.e. exactly one cycle after L_HOLD, or first edge after rst_p release).
- Unloaded addresses keep prior contents (no clear on load_start).

## Timing
- Reset values: cpu_rst=1, host_ready=0, load_busy=0, load_done=0, wr_err=0, cpu_data=0 (memory zero).
- Read latency 0 cycles (combinational from bus_addr); store write visible on cpu_data the cycle after the data-phase edge.
- Host transfer occurs at posedge with host_valid & host_ready; host_ready drops the cycle after the final transfer.
- Load of N nibbles: load_start edge + N transfer edges + 1 L_HOLD cycle; cpu_rst low from 2 edges after last transfer.
- rst_p mid-load or mid-store: all FSMs to idle, memory cleared, partial write discarded.
- Simultaneous load_start with store address phase: load wins, store discarded, no wr_err.

## Structure
- Shared package: store-FSM and load-FSM state enums, BUS_ADDR_W=6, BUS_DATA_W=4 (common with the CPU).
- One sub-module natural: nibble_bus_mem_array (64xDATA_W flop array, async reset, one write port, one async read port); write mux between store and load paths in the top.

## Test plan
- Reset: assert rst_p -> cpu_rst=1, all flags 0, cpu_data=0 for every bus_addr.
- Host load 3 nibbles A,5,C (last on C) -> mem[0..2]=A,5,C, load_done pulse once, cpu_rst low 2 cycles after C accepted.
- Store: wcyc=1 with bus_addr=0x2A, next cycle wcyc=1 bus_addr=0x07 -> mem[0x2A]=7, cpu_data=7 when bus_addr=0x2A next cycle.
- Broken store: wcyc=1 addr 0x10 then wcyc=0 -> mem[0x10] unchanged, wr_err=1; next load_start clears it.
- Full load of 64 nibbles without host_last -> load ends after address 63, host_ready=0, load_ptr no wrap, mem[0] intact.
- rst_p pulse mid-load after 2 nibbles -> memory all 0, load_busy=0, cpu_rst=1.
